issue_unit: RTL and testbench
=============================

Name: issue_unit

Overview:
- Consumer end of the 8-entry instruction FIFO: pops 16-bit instructions, decodes them and dispatches them to the Tomasulo reservation stations.
- Owns the register status table (Qi per architectural register).
- Reads operands from the register file, forwarding from the CDB when a result is broadcast in the same cycle.
- Sits between the instruction queue and the ADD/MUL/LS reservation station banks.

Parameters:
- DW, 16, operand data width.
- NREG, 8, architectural registers (3-bit index; fixed by the encoding).

Ports:
- CLK  in  1  clock
- CLR  in  1  reset, asynchronous, active-high
- q_vazio  in  1  queue empty flag
- q_cheio  in  1  queue full flag
- q_adc  in  1  queue write request; the queue gives writes priority over reads
- q_rtr  out  1  pop request (combinational)
- q_instr  in  16  queue output; valid from the cycle after an effective pop and stable until the next one
- rs_busy  in  7  station busy bits: [0..2] ADD/SUB (tags 1-3), [3..4] MUL/DIV (tags 4-5), [5..6] LD/ST (tags 6-7)
- rs_we  out  7  one-hot station write strobe
- rs_op  out  2  sub-op within the class: 0 ADD/MUL/LD, 1 SUB/DIV/ST
- rs_vj, rs_vk  out  DW  operand values
- rs_qj, rs_qk  out  3  operand producer tags, 0 = value ready
- rf_ra1, rf_ra2  out  3  register file read addresses
- rf_rd1, rf_rd2  in  DW  combinational read data
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  3  broadcasting station tag (1-7)
- cdb_data  in  DW  broadcast value
- rf_wmask  out  NREG  registers that must capture cdb_data this cycle (combinational)
- stall  out  1  valid instruction held but no station free

Behaviour:
- Encoding: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [5:0] imm.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LD, 5 ST. Opcodes 6-15 are discarded in HOLD with no dispatch and no Qi change.
- Effective pop = q_rtr & ~q_vazio & ~(q_adc & ~q_cheio). Only an effective pop advances the FSM.
- FSM IDLE: q_rtr = ~q_vazio. Effective pop -> HOLD; otherwise stay in IDLE.
- FSM HOLD (q_instr valid):
  - Station selection: lowest-index free station of the opcode's class.
  - If a station is free: pulse its rs_we bit for one cycle and assert q_rtr = ~q_vazio in the same cycle. Effective pop -> stay in HOLD; otherwise -> IDLE.
  - If no station is free: stall=1, rs_we=0, q_rtr=0, stay in HOLD.
- Operand sources:
  - ALU ops: j=rs, k=rt.
  - LD: j=rs; vk = zero-extended imm; qk = 0.
  - ST: j=rs (base), k=rd (data).
- Operand resolution, per operand, at the dispatch cycle:
  - Qi[src]==0: V = rf data, Q = 0.
  - Else if cdb_valid & cdb_tag==Qi[src]: V = cdb_data, Q = 0.
  - Else: Q = Qi[src], V = don't care.
- Qi update at the dispatch edge: ALU ops and LD write Qi[rd] = the tag of the selected station. ST leaves Qi unchanged.
- CDB clear: on cdb_valid, every r with Qi[r]==cdb_tag is cleared to 0 and its rf_wmask[r] bit is 1 that cycle. If the same edge dispatches a write to r, the dispatch's new tag wins over the clear.
- rd==rs or rd==rt: operands resolve from the pre-update Qi, then Qi[rd] is rewritten.
- rf_wmask is purely combinational from Qi and the CDB inputs.
- Reset (asynchronous, any state, including mid-HOLD): state=IDLE, all Qi=0, rs_we=0, stall=0. The held instruction is lost, and q_rtr follows q_vazio immediately after reset.
- Latency: at most one issue per cycle. Effective pop to earliest dispatch is 1 cycle; back-to-back dispatch is possible while the queue is non-empty and stations are free.

Test Plan:
- Reset, push ADD r1,r2,r3 with all Qi=0 and rf_rd=0x0005/0x0003 -> one cycle after the effective pop: rs_we=0000001, vj=5, vk=3, qj=qk=0; Qi[1]=1.
- Then MUL r4,r1,r1 -> rs_we=0001000, qj=qk=1; Qi[4]=4. Next, cdb_valid with tag 1, data 0x0008 -> rf_wmask=00000010 and Qi[1]=0.
- Issue four ADDs while ADD stations stay busy -> three dispatch with tags 1, 2, 3; the fourth holds with stall=1 and q_rtr=0. Free station 1 -> the fourth dispatches with tag 2.
- q_adc=1 with q_cheio=0 in the same cycle as q_rtr -> no FSM advance; the pop is retried the next cycle.
- Dispatch SUB r2,r1,r0 in the same cycle as CDB tag 1 (=Qi[1]) with data 0x00AA -> vj=0x00AA, qj=0.
- Dispatch writing r3 while the CDB clears r3 -> Qi[3] holds the new tag.
- Assert CLR while in HOLD with stall=1 -> rs_we=0 and all Qi=0 immediately; the held instruction is never dispatched.
- Opcode 0xF -> popped and discarded; rs_we stays 0 and Qi is unchanged.

Source files
------------

// File: rtl/issue_unit.sv
// Issue stage: pops instructions from the instruction queue, resolves operands through the
// register status table (Qi) and the CDB, and dispatches into the first free reservation station.
module issue_unit #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            q_vazio,
    input  logic            q_cheio,
    input  logic            q_adc,
    output logic            q_rtr,
    input  logic [15:0]     q_instr,
    input  logic [6:0]      rs_busy,
    output logic [6:0]      rs_we,
    output logic [1:0]      rs_op,
    output logic [DW-1:0]   rs_vj,
    output logic [DW-1:0]   rs_vk,
    output logic [2:0]      rs_qj,
    output logic [2:0]      rs_qk,
    output logic [2:0]      rf_ra1,
    output logic [2:0]      rf_ra2,
    input  logic [DW-1:0]   rf_rd1,
    input  logic [DW-1:0]   rf_rd2,
    input  logic            cdb_valid,
    input  logic [2:0]      cdb_tag,
    input  logic [DW-1:0]   cdb_data,
    output logic [NREG-1:0] rf_wmask,
    output logic            stall
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [NREG-1:0][2:0] qi_q, qi_d;

    logic [3:0] opc;
    logic [2:0] rd, rs, rt, src_k;
    logic [5:0] imm;
    logic       op_valid, is_ld, is_st;

    assign opc      = q_instr[15:12];
    assign rd       = q_instr[11:9];
    assign rs       = q_instr[8:6];
    assign rt       = q_instr[5:3];
    assign imm      = q_instr[5:0];
    assign op_valid = (opc < 4'd6);
    assign is_ld    = (opc == 4'd4);
    assign is_st    = (opc == 4'd5);
    // Stores read their data register through the k port.
    assign src_k    = is_st ? rd : rt;

    logic [6:0] cls_mask, avail, sel;
    logic [2:0] sel_tag;

    always_comb begin
        cls_mask = '0;
        case (opc)
            4'd0, 4'd1: cls_mask = 7'b0000111;
            4'd2, 4'd3: cls_mask = 7'b0011000;
            4'd4, 4'd5: cls_mask = 7'b1100000;
            default:    cls_mask = '0;
        endcase
    end

    assign avail = cls_mask & ~rs_busy;
    assign sel   = avail & (~avail + 7'd1);

    always_comb begin
        sel_tag = '0;
        for (int i = 0; i < 7; i++) begin
            if (sel[i]) sel_tag = 3'(i + 1);
        end
    end

    logic in_hold, dispatch, pop;

    assign in_hold  = (state_q == HOLD);
    assign dispatch = in_hold & op_valid & (|avail);
    assign stall    = in_hold & op_valid & ~(|avail);
    assign q_rtr    = ~q_vazio & ~stall;
    // The queue services a concurrent write first, so the read is lost that cycle.
    assign pop      = q_rtr & ~q_vazio & ~(q_adc & ~q_cheio);
    assign state_d  = (stall | pop) ? HOLD : IDLE;

    assign rs_we  = dispatch ? sel : 7'd0;
    assign rs_op  = {1'b0, opc[0]};
    assign rf_ra1 = rs;
    assign rf_ra2 = src_k;

    logic [2:0] qi_j, qi_k;

    assign qi_j = qi_q[rs];
    assign qi_k = qi_q[src_k];

    always_comb begin
        rs_vj = rf_rd1;
        rs_qj = '0;
        if (qi_j != 3'd0) begin
            if (cdb_valid && (cdb_tag == qi_j)) rs_vj = cdb_data;
            else                                rs_qj = qi_j;
        end
        rs_vk = rf_rd2;
        rs_qk = '0;
        if (is_ld) begin
            rs_vk = {{(DW-6){1'b0}}, imm};
        end else if (qi_k != 3'd0) begin
            if (cdb_valid && (cdb_tag == qi_k)) rs_vk = cdb_data;
            else                                rs_qk = qi_k;
        end
    end

    always_comb begin
        rf_wmask = '0;
        for (int r = 0; r < NREG; r++) begin
            rf_wmask[r] = cdb_valid && (cdb_tag != 3'd0) && (qi_q[r] == cdb_tag);
        end
    end

    always_comb begin
        qi_d = qi_q;
        for (int r = 0; r < NREG; r++) begin
            if (rf_wmask[r]) qi_d[r] = '0;
        end
        // A new producer for rd overrides a same-cycle CDB clear.
        if (dispatch && !is_st) qi_d[rd] = sel_tag;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            qi_q    <= '0;
        end else begin
            state_q <= state_d;
            qi_q    <= qi_d;
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: models the instruction queue, register file and station busy
// bits; expected dispatches are queued on push and compared when rs_we fires.
module tb_issue_unit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        q_vazio, q_cheio, q_adc, q_rtr;
    logic [15:0] q_instr;
    logic [6:0]  rs_busy, rs_we;
    logic [1:0]  rs_op;
    logic [15:0] rs_vj, rs_vk, rf_rd1, rf_rd2, cdb_data;
    logic [2:0]  rs_qj, rs_qk, rf_ra1, rf_ra2, cdb_tag;
    logic        cdb_valid, stall;
    logic [7:0]  rf_wmask;

    typedef struct {
        logic [6:0]  we;
        logic [1:0]  op;
        logic [15:0] vj;
        logic [15:0] vk;
        logic [2:0]  qj;
        logic [2:0]  qk;
    } disp_t;

    disp_t       exp_q[$];
    logic [15:0] fifo[$];
    logic [15:0] rf[8];
    int          ncmp = 0;
    int          nerr = 0;

    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];

    always #10 CLK = ~CLK;

    issue_unit dut (
        .CLK(CLK), .CLR(CLR),
        .q_vazio(q_vazio), .q_cheio(q_cheio), .q_adc(q_adc), .q_rtr(q_rtr), .q_instr(q_instr),
        .rs_busy(rs_busy), .rs_we(rs_we), .rs_op(rs_op),
        .rs_vj(rs_vj), .rs_vk(rs_vk), .rs_qj(rs_qj), .rs_qk(rs_qk),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rf_wmask(rf_wmask), .stall(stall)
    );

    function automatic logic [15:0] enc(input logic [3:0] o, input logic [2:0] d,
                                        input logic [2:0] s, input logic [2:0] t);
        return {o, d, s, t, 3'b000};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic push(input logic [15:0] instr);
        fifo.push_back(instr);
        q_vazio = 1'b0;
    endtask

    task automatic expect_disp(input logic [6:0] we, input logic [1:0] op, input logic [15:0] vj,
                               input logic [15:0] vk, input logic [2:0] qj, input logic [2:0] qk);
        disp_t e;
        e.we = we; e.op = op; e.vj = vj; e.vk = vk; e.qj = qj; e.qk = qk;
        exp_q.push_back(e);
    endtask

    // One clock: queue model pops on an effective pop, stations become busy on dispatch.
    task automatic tick();
        logic       pop_now;
        logic [6:0] we_now;
        #1;
        pop_now = q_rtr & ~q_vazio & ~(q_adc & ~q_cheio);
        we_now  = rs_we;
        @(posedge CLK);
        #1;
        rs_busy   = rs_busy | we_now;
        if (pop_now) q_instr = fifo.pop_front();
        q_vazio   = (fifo.size() == 0);
        cdb_valid = 1'b0;
        q_adc     = 1'b0;
        #1;
    endtask

    task automatic chk_disp(input string name);
        disp_t e;
        ncmp++;
        assert (exp_q.size() != 0) else begin
            nerr++;
            $error("FAIL %s: observed dispatch we=%b expected none queued", name, rs_we);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({name, ".we"}, 32'(rs_we), 32'(e.we));
            chk({name, ".op"}, 32'(rs_op), 32'(e.op));
            chk({name, ".qj"}, 32'(rs_qj), 32'(e.qj));
            chk({name, ".qk"}, 32'(rs_qk), 32'(e.qk));
            if (e.qj == 3'd0) chk({name, ".vj"}, 32'(rs_vj), 32'(e.vj));
            if (e.qk == 3'd0) chk({name, ".vk"}, 32'(rs_vk), 32'(e.vk));
        end
    endtask

    // Non-destructive look at Qi: rf_wmask is combinational, CDB dropped before the edge.
    task automatic probe(input logic [2:0] t, input logic [7:0] m, input string name);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = 16'hDEAD;
        #1;
        chk(name, 32'(rf_wmask), 32'(m));
        cdb_valid = 1'b0;
        #1;
    endtask

    task automatic cdb_pulse(input logic [2:0] t, input logic [7:0] m, input string name);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = 16'h0BAD;
        #1;
        chk(name, 32'(rf_wmask), 32'(m));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h11);
        rf[2] = 16'h0005;
        rf[3] = 16'h0003;
        CLR = 1'b1; q_vazio = 1'b1; q_cheio = 1'b0; q_adc = 1'b0; q_instr = 16'h0000;
        rs_busy = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        #5;
        chk("reset.we", 32'(rs_we), 32'h0);
        chk("reset.stall", 32'(stall), 32'h0);
        chk("reset.rtr", 32'(q_rtr), 32'h0);
        probe(3'd1, 8'h00, "reset.qi");
        CLR = 1'b0;
        @(negedge CLK);

        // ADD r1,r2,r3 with a colliding queue write first, then back-to-back MUL r4,r1,r1.
        push(enc(4'd0, 3'd1, 3'd2, 3'd3));
        expect_disp(7'b0000001, 2'd0, 16'h0005, 16'h0003, 3'd0, 3'd0);
        q_adc = 1'b1;
        #1;
        chk("adc.rtr", 32'(q_rtr), 32'h1);
        tick();
        chk("adc.no_advance_we", 32'(rs_we), 32'h0);
        chk("adc.retry_rtr", 32'(q_rtr), 32'h1);
        tick();
        push(enc(4'd2, 3'd4, 3'd1, 3'd1));
        expect_disp(7'b0001000, 2'd0, 16'h0000, 16'h0000, 3'd1, 3'd1);
        #1;
        chk_disp("add1");
        chk("add1.stall", 32'(stall), 32'h0);
        tick();
        chk_disp("mul1");
        tick();
        chk("idle.we", 32'(rs_we), 32'h0);
        probe(3'd4, 8'h10, "qi4.mul");
        probe(3'd1, 8'h02, "qi1.add");
        cdb_pulse(3'd1, 8'h02, "cdb1.wmask");
        probe(3'd1, 8'h00, "qi1.cleared");

        // Four ADDs against three ADD stations.
        rs_busy = '0;
        push(enc(4'd0, 3'd5, 3'd2, 3'd3));
        expect_disp(7'b0000001, 2'd0, 16'h0005, 16'h0003, 3'd0, 3'd0);
        push(enc(4'd0, 3'd6, 3'd3, 3'd2));
        expect_disp(7'b0000010, 2'd0, 16'h0003, 16'h0005, 3'd0, 3'd0);
        push(enc(4'd0, 3'd7, 3'd1, 3'd2));
        expect_disp(7'b0000100, 2'd0, 16'h0011, 16'h0005, 3'd0, 3'd0);
        push(enc(4'd0, 3'd2, 3'd4, 3'd3));
        expect_disp(7'b0000010, 2'd0, 16'h0000, 16'h0003, 3'd4, 3'd0);
        tick();
        chk_disp("add_a");
        tick();
        chk_disp("add_b");
        tick();
        chk_disp("add_c");
        tick();
        push(enc(4'hF, 3'd5, 3'd0, 3'd0));
        #1;
        chk("full.stall", 32'(stall), 32'h1);
        chk("full.we", 32'(rs_we), 32'h0);
        chk("full.rtr", 32'(q_rtr), 32'h0);
        tick();
        chk("full.stall2", 32'(stall), 32'h1);
        rs_busy[1] = 1'b0;
        #1;
        chk_disp("add_d");
        chk("add_d.rtr", 32'(q_rtr), 32'h1);
        tick();
        chk("discard.we", 32'(rs_we), 32'h0);
        chk("discard.stall", 32'(stall), 32'h0);
        tick();
        probe(3'd2, 8'h44, "qi.tag2");
        probe(3'd1, 8'h20, "qi.discard_kept");
        probe(3'd3, 8'h80, "qi.tag3");
        cdb_pulse(3'd1, 8'h20, "clr1");
        cdb_pulse(3'd2, 8'h44, "clr2");
        cdb_pulse(3'd3, 8'h80, "clr3");
        cdb_pulse(3'd4, 8'h10, "clr4");

        // SUB r2,r1,r0 forwarding r1 from the CDB in its dispatch cycle.
        rs_busy = '0;
        push(enc(4'd0, 3'd1, 3'd2, 3'd3));
        expect_disp(7'b0000001, 2'd0, 16'h0005, 16'h0003, 3'd0, 3'd0);
        push(enc(4'd1, 3'd2, 3'd1, 3'd0));
        expect_disp(7'b0000010, 2'd1, 16'h00AA, 16'h0000, 3'd0, 3'd0);
        tick();
        chk_disp("fwd.add");
        tick();
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h00AA;
        #1;
        chk_disp("fwd.sub");
        chk("fwd.wmask", 32'(rf_wmask), 32'h02);
        tick();
        probe(3'd1, 8'h00, "fwd.qi1");
        probe(3'd2, 8'h04, "fwd.qi2");

        // ADD r3,r3,r0 dispatched while the CDB clears r3: new tag wins.
        rs_busy = '0;
        push(enc(4'd2, 3'd3, 3'd0, 3'd0));
        expect_disp(7'b0001000, 2'd0, 16'h0000, 16'h0000, 3'd0, 3'd0);
        push(enc(4'd0, 3'd3, 3'd3, 3'd0));
        expect_disp(7'b0000001, 2'd0, 16'h0123, 16'h0000, 3'd0, 3'd0);
        tick();
        chk_disp("race.mul");
        tick();
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h0123;
        #1;
        chk_disp("race.add");
        chk("race.wmask", 32'(rf_wmask), 32'h08);
        tick();
        probe(3'd1, 8'h08, "race.qi3_new");
        probe(3'd4, 8'h00, "race.qi3_old");

        // LD r6,r2,#0x2D then ST r3 -> [r0].
        rs_busy = '0;
        push({4'd4, 3'd6, 3'd2, 6'h2D});
        expect_disp(7'b0100000, 2'd0, 16'h0000, 16'h002D, 3'd2, 3'd0);
        push({4'd5, 3'd3, 3'd0, 6'h00});
        expect_disp(7'b1000000, 2'd1, 16'h0000, 16'h0000, 3'd0, 3'd1);
        tick();
        chk_disp("ld");
        tick();
        chk_disp("st");
        tick();
        probe(3'd6, 8'h40, "ld.qi6");
        probe(3'd1, 8'h08, "st.qi_unchanged");
        probe(3'd7, 8'h00, "st.no_tag7");

        // Reset while stalled in HOLD: held instruction is dropped.
        rs_busy = 7'h7F;
        push(enc(4'd0, 3'd5, 3'd0, 3'd0));
        tick();
        push(enc(4'd0, 3'd7, 3'd2, 3'd3));
        expect_disp(7'b0000001, 2'd0, 16'h0005, 16'h0003, 3'd0, 3'd0);
        #1;
        chk("clr.pre_stall", 32'(stall), 32'h1);
        chk("clr.pre_rtr", 32'(q_rtr), 32'h0);
        CLR = 1'b1;
        #1;
        chk("clr.we", 32'(rs_we), 32'h0);
        chk("clr.stall", 32'(stall), 32'h0);
        chk("clr.rtr", 32'(q_rtr), 32'h1);
        probe(3'd6, 8'h00, "clr.qi6");
        probe(3'd2, 8'h00, "clr.qi2");
        CLR = 1'b0;
        rs_busy = '0;
        tick();
        chk_disp("post_clr");
        tick();
        chk("post_clr.idle_we", 32'(rs_we), 32'h0);
        chk("scoreboard.empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
